// File: rtl/nibble_serial_addsub.sv
// Serial adder/subtractor: one nibble per cycle through a 4-bit CLA.
// A final RUN cycle registers the flags from the completed result.
module nibble_serial_addsub #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = $clog2(NIB + 1);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             cy;
    logic             fin;
    logic [3:0]       na;
    logic [3:0]       nb;
    logic [3:0]       g;
    logic [3:0]       p;
    logic [3:0]       ns;
    logic [4:0]       c;

    // cnt == NIB marks the flag-capture cycle after the last nibble
    assign fin = (cnt == CW'(NIB));

    always_comb begin
        na = '0;
        nb = '0;
        for (int k = 0; k < NIB; k++) begin
            if (cnt == CW'(k)) begin
                na = opa[4*k +: 4];
                nb = opb[4*k +: 4];
            end
        end
    end

    assign g    = na & nb;
    assign p    = na ^ nb;
    assign c[0] = cy;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);
    assign ns   = p ^ c[3:0];

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = RUN;
            RUN:  if (fin) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            opa    <= '0;
            opb    <= '0;
            cy     <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        opa <= a;
                        opb <= sub ? ~b : b;
                        cy  <= sub;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    if (!fin) begin
                        for (int k = 0; k < NIB; k++) begin
                            if (cnt == CW'(k)) result[4*k +: 4] <= ns;
                        end
                        cy  <= c[4];
                        cnt <= cnt + 1'b1;
                    end else begin
                        cout <= cy;
                        ovf  <= (opa[MSB] == opb[MSB]) &&
                                (result[MSB] != opa[MSB]);
                        zero <= (result == '0);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Scoreboard bench for nibble_serial_addsub: directed vectors,
// expectations queued at issue and checked when done pulses.
module tb_nibble_serial_addsub;
    localparam int W = 32;
    localparam int LAT = 9;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;
    logic         zero;

    nibble_serial_addsub #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf),
        .zero   (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         o;
        logic         z;
        int           cyc;
        string        name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    logic [W-1:0] last_r = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL spurious_done: got done=1 expected 0 at cyc %0d",
                         cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk({e.name, ".result"}, result, e.r);
                chk({e.name, ".cout"}, W'(cout), W'(e.c));
                chk({e.name, ".ovf"}, W'(ovf), W'(e.o));
                chk({e.name, ".zero"}, W'(zero), W'(e.z));
                chk({e.name, ".latency"}, W'(cyc), W'(e.cyc));
            end
        end
    end

    task automatic goto(int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while (busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (busy) begin
            n_chk++;
            n_err++;
            $display("FAIL idle_timeout: got busy=1 expected 0");
        end
    endtask

    // drives start in one cycle; returns #1 after the accepting edge
    task automatic issue(string nm, logic [W-1:0] ai, logic [W-1:0] bi,
                         logic si, logic [W-1:0] r, logic c, logic o,
                         logic z, bit push, output int acc);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        a = ai;
        b = bi;
        sub = si;
        @(posedge clk);
        #1;
        acc = cyc;
        start = 1'b0;
        a = 32'hDEAD_BEEF;
        b = 32'h0BAD_F00D;
        sub = ~si;
        if (push) begin
            e.r = r;
            e.c = c;
            e.o = o;
            e.z = z;
            e.cyc = acc + LAT;
            e.name = nm;
            q.push_back(e);
            last_r = r;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int t;
        rst_n = 1'b0;
        #1;
        chk("rst.result", result, '0);
        chk("rst.flags", W'({busy, done, cout, ovf, zero}), '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        issue("add5p3", 32'h5, 32'h3, 0, 32'h8, 0, 0, 0, 1, t);
        wait_idle();
        issue("addwrap", 32'hFFFF_FFFF, 32'h1, 0, 32'h0, 1, 0, 1, 1, t);
        wait_idle();
        issue("addovf", 32'h7FFF_FFFF, 32'h1, 0,
              32'h8000_0000, 0, 1, 0, 1, t);
        wait_idle();
        issue("sub0m1", 32'h0, 32'h1, 1, 32'hFFFF_FFFF, 0, 0, 0, 1, t);
        wait_idle();
        issue("subovf", 32'h8000_0000, 32'h1, 1,
              32'h7FFF_FFFF, 1, 1, 0, 1, t);
        wait_idle();
        issue("subeq", 32'h1234_5678, 32'h1234_5678, 1,
              32'h0, 1, 0, 1, 1, t);
        wait_idle();
        issue("addmix", 32'h89AB_CDEF, 32'h7654_3210, 0,
              32'hFFFF_FFFF, 0, 0, 0, 1, t);
        wait_idle();
        issue("addneg", 32'h8000_0000, 32'h8000_0000, 0,
              32'h0, 1, 1, 1, 1, t);
        wait_idle();

        // restarts during RUN and DONE must be ignored
        issue("busyA", 32'h0000_00FF, 32'h0000_0001, 0,
              32'h0000_0100, 0, 0, 0, 1, t);
        goto(t + 3);
        start = 1'b1;
        a = 32'h1111_1111;
        b = 32'h2222_2222;
        sub = 1'b0;
        chk("busy.run3", W'(busy), W'(1));
        @(negedge clk);
        start = 1'b0;
        goto(t + 9);
        start = 1'b1;
        a = 32'h3333_3333;
        b = 32'h4444_4444;
        chk("busy.done9", W'(busy), W'(1));
        chk("done.at9", W'(done), W'(1));
        issue("afterdone", 32'h5, 32'h7, 1,
              32'hFFFF_FFFE, 0, 0, 0, 1, t);
        wait_idle();

        // reset in the middle of RUN aborts without done
        issue("abort", 32'h1, 32'h1, 0, 32'h2, 0, 0, 0, 0, t);
        goto(t + 4);
        rst_n = 1'b0;
        #1;
        chk("abort.result", result, '0);
        chk("abort.flags", W'({busy, done, cout, ovf, zero}), '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        issue("postrst", 32'h0000_1000, 32'h0000_0FFF, 0,
              32'h0000_1FFF, 0, 0, 0, 1, t);
        wait_idle();

        repeat (3) @(negedge clk);
        chk("hold.result", result, last_r);
        chk("sb.empty", W'(q.size()), W'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/nibble_serial_addsub.md
NIBBLE_SERIAL_ADDSUB -- requirements
Module: nibble_serial_addsub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: operand and result width in bits; SHALL be a multiple of 4 and at least 8.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request a new operation.
REQ-005 The block SHALL have port sub, input, 1 bit: 0 selects a+b; 1 selects a-b.
REQ-006 The block SHALL have ports a and b, input, WIDTH bits each: operands, sampled on the cycle start is accepted.
REQ-007 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse when result and flags are final.
REQ-009 The block SHALL have port result, output, WIDTH bits: sum or difference.
REQ-010 The block SHALL have port cout, output, 1 bit: final carry out (for subtraction, 1 = no borrow).
REQ-011 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow.
REQ-012 The block SHALL have port zero, output, 1 bit: high when result == 0.

Function
REQ-013 The block SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-014 In IDLE, start=1 SHALL cause the block to:
- latch a;
- latch b, or ~b when sub=1;
- load the carry register with sub;
- clear the nibble counter;
- enter RUN.
REQ-015 In RUN, each cycle SHALL add nibble k of the latched operands plus the carry register through exactly one 4-bit carry-lookahead adder (lowest nibble first, k = 0 .. WIDTH/4-1).
REQ-016 In each RUN cycle, the 4-bit sum SHALL be written to result[4k+3:4k], and the nibble carry-out SHALL be stored in the carry register.
REQ-017 After nibble WIDTH/4-1, the FSM SHALL enter DONE.
- On entry to DONE: cout = final carry; ovf = (a[MSB] == b'[MSB]) && (result[MSB] != a[MSB]), where b' is the latched, possibly inverted, operand; zero = (result == 0).
- done SHALL be 1 for exactly the DONE cycle; the FSM then returns to IDLE.
REQ-018 Latency SHALL be fixed: start accepted at edge t, done high in the cycle after edge t+WIDTH/4+1 (WIDTH=32: 9 cycles after acceptance), independent of operand values.
REQ-019 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-020 start SHALL be ignored while busy=1; a new start is accepted no earlier than the cycle after done.
REQ-021 result, cout, ovf and zero SHALL hold their values from done until the next accepted start; result nibbles not yet processed are undefined-free (held at prior value) during RUN.
REQ-022 The a, b and sub inputs SHALL be don't-care except in the accepting cycle.

Reset
REQ-023 rst_n=0 SHALL asynchronously force state=IDLE, nibble counter=0, carry register=0, result=0, busy=0, done=0, cout=0, ovf=0, zero=0, and clear the operand latches.
REQ-024 Reset asserted mid-operation SHALL abort the operation with no done pulse.
REQ-025 After release of reset, the first rising edge with start=1 SHALL be accepted.

Verification
REQ-026 The bench SHALL cover: a=0x00000005, b=0x00000003, sub=0 -> done at 9 cycles, result=0x00000008, cout=0, ovf=0, zero=0.
REQ-027 The bench SHALL cover: a=0xFFFFFFFF, b=0x00000001, sub=0 -> result=0x00000000, cout=1, ovf=0, zero=1.
REQ-028 The bench SHALL cover: a=0x7FFFFFFF, b=0x00000001, sub=0 -> result=0x80000000, cout=0, ovf=1.
REQ-029 The bench SHALL cover: a=0x00000000, b=0x00000001, sub=1 -> result=0xFFFFFFFF, cout=0, ovf=0. Also a=0x80000000, b=1, sub=1 -> result=0x7FFFFFFF, ovf=1.
REQ-030 The bench SHALL cover: start pulsed again at cycles 3 and 9 (DONE) of an operation -> both ignored, busy stays 1, single done pulse; start the cycle after done is accepted.
REQ-031 The bench SHALL cover: rst_n driven low at RUN cycle 4 -> all outputs 0 immediately, no done pulse; the next start completes normally with correct result.
